apb_master_arbiter: RTL and testbench
=====================================

# apb_master_arbiter

Two-master APB arbiter that shares the single APB master port of the `amba_apb_bus` between the CPU memory bridge (master 0) and a second bus master (master 1), such as an offload or IO-streaming engine. Each master sees a standard APB master interface and is stalled with `pready` low until it is granted. The arbiter replays the granted transfer downstream as a fresh setup/access sequence. It also returns an error response on a peripheral that never answers.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `NSEL`, 8, width of the one-hot peripheral select bus
- `FIXED_PRIO`, 0: 0 = round-robin, 1 = master 0 always wins ties
- `TIMEOUT`, 255: maximum access-phase cycles before abort; 0 disables the timeout
- `ERR_DATA`, 32'hDEAD_BEEF: read data returned on a timeout

Ports:
- `clk`  in  1  single clock; the bus clock domain
- `rst`  in  1  reset; synchronous, active-high
- `m0_psel`, `m1_psel`  in  NSEL  master select; any bit high = request
- `m0_penable`, `m1_penable`  in  1  master access phase
- `m0_pwrite`, `m1_pwrite`  in  1  1 = write
- `m0_paddr`, `m1_paddr`  in  ADDR_W  address
- `m0_pwdata`, `m1_pwdata`  in  DATA_W  write data
- `m0_pready`, `m1_pready`  out  1  transfer complete to the master
- `m0_prdata`, `m1_prdata`  out  DATA_W  read data to the master
- `s_psel`  out  NSEL  downstream select
- `s_penable`  out  1  downstream access phase
- `s_pwrite`  out  1  downstream write
- `s_paddr`  out  ADDR_W  downstream address
- `s_pwdata`  out  DATA_W  downstream write data
- `s_pready`  in  1  downstream ready
- `s_prdata`  in  DATA_W  downstream read data
- `grant`  out  2  one-hot owner of the downstream bus; 0 when idle
- `timeout`  out  1  one-cycle pulse when a transfer is aborted

## Operation
- **Request:** `reqN = |mN_psel`.
- **IDLE**
  - With no request, stay in IDLE.
  - With requests pending, pick a winner:
    - `FIXED_PRIO=1`: master 0 wins.
    - `FIXED_PRIO=0`: the master not granted last wins.
    - With a single request, that master wins.
  - Latch the winner's `psel`, `pwrite`, `paddr` and `pwdata`; set `grant`; go to SETUP.
- **SETUP:** drive `s_psel` = latched select, `s_penable`=0, with the latched address, data and direction. Go to ACCESS.
- **ACCESS:** `s_penable`=1 and the timeout counter increments.
  - If `s_pready`=1:
    - Combinationally drive the granted master's `pready`=1 and `prdata`=`s_prdata`.
    - Record the last-grant pointer; go to IDLE.
  - Else if `TIMEOUT`≠0 and counter = `TIMEOUT`-1:
    - Drive granted `pready`=1 and `prdata`=`ERR_DATA`.
    - Pulse `timeout`; record the pointer; go to IDLE.
- The non-granted master always sees `pready`=0 and `prdata`=0.
- Downstream signals are fed from the latched copies only. Changes on a master's inputs after latching are ignored until the next IDLE.
- A master that drops `psel` while granted still has its transfer completed downstream; the `pready` pulse is still issued.

## Timing
- **Reset values:** all outputs 0, state IDLE, pointer = master 1, so master 0 wins the first round-robin tie. Counter 0.
- **Uncontended latency:**
  - Master setup at cycle N: arbiter latches at N, `s_psel` rises at N+1, `s_penable` rises at N+2.
  - With zero downstream wait states, master `pready` is seen at N+2: one extra wait state versus a direct connection.
- **Back-to-back:** the cycle after completion is IDLE. It samples the masters' updated signals, so a completed transfer is never regranted. The minimum downstream gap between transfers is one idle cycle.
- **Simultaneous requests:** under round-robin, alternating grants m0, m1, m0, ... while both requesters stay asserted.
- **Timeout:** the abort happens on the `TIMEOUT`-th access cycle; `s_penable` and `s_psel` drop on the next edge.
- **Reset:** `rst` mid-transfer forces IDLE and zero outputs at the next edge. The downstream transfer is abandoned and no `pready` is issued.

## Structure
- **Package `apb_arb_pkg`:** state enum (IDLE, SETUP, ACCESS), default `ERR_DATA`, default `NSEL`.
- **Sub-module `apb_arb_pick2`:** combinational 2-way winner select, taking `req[1:0]`, the last-grant pointer and `FIXED_PRIO`, and producing one-hot `win`.
- **Top level:** the FSM, capture registers, timeout counter and response muxing.

## Test plan
- **Single read:** m0 reads `paddr`=0x10, `psel`=8'h01, with `s_pready` high immediately and `s_prdata`=0x1234_5678 → `s_psel` at N+1, `s_penable` at N+2, `m0_pready` and `m0_prdata`=0x1234_5678 at N+2; `m1_pready` stays 0.
- **Contention:** m0 and m1 request together from reset, four transfers each, round-robin → `grant` sequence 01, 10, 01, 10, ...; with `FIXED_PRIO=1`, all four m0 transfers complete before any m1 transfer.
- **Wait states:** m1 writes 0xCAFE_F00D with `s_pready` low for 5 cycles → `s_pwdata` held stable throughout; `m1_pready` occurs exactly in the cycle `s_pready` rises.
- **Timeout:** `TIMEOUT`=4 and `s_pready` never asserts → `timeout` pulses on the 4th ACCESS cycle, `m0_prdata`=0xDEAD_BEEF with `pready`=1, and `s_psel`=0 next cycle.
- **Reset mid-operation:** assert `rst` in ACCESS → the next edge gives all outputs 0 and `grant`=0; afterwards a fresh m0 request is served normally.

Source files
------------

// File: rtl/apb_arb_pkg.sv
// Shared definitions for the two-master APB arbiter.
//   arb_state_t      : arbiter FSM states (IDLE -> SETUP -> ACCESS)
//   ARB_NSEL_DEF     : default width of the one-hot peripheral select bus
//   ARB_ERR_DATA_DEF : default read data returned when a transfer times out
package apb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } arb_state_t;

  localparam int          ARB_NSEL_DEF     = 8;
  localparam logic [31:0] ARB_ERR_DATA_DEF = 32'hDEAD_BEEF;

endpackage

// File: rtl/apb_arb_pick2.sv
// Combinational two-way winner select.
//   req  [1:0] : request per master (bit 0 = master 0)
//   last       : 1 when master 1 held the last grant, 0 for master 0
//   win  [1:0] : one-hot winner, 0 when nobody requests
// FIXED_PRIO != 0 makes master 0 win every tie; otherwise a tie goes to
// the master that was not granted last.
module apb_arb_pick2 #(
  parameter int FIXED_PRIO = 0
) (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] win
);

  always_comb begin
    win = req;
    if (req == 2'b11) begin
      if ((FIXED_PRIO != 0) || last) win = 2'b01;
      else                           win = 2'b10;
    end
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// Two-master APB arbiter sharing one downstream APB master port.
//   clk, rst                : bus clock, synchronous active-high reset
//   m0_* / m1_*             : APB master-side inputs (psel/penable/pwrite/
//                             paddr/pwdata) and responses (pready/prdata)
//   s_*                     : downstream APB master port
//   grant [1:0]             : one-hot owner of the downstream bus, 0 when idle
//   timeout                 : one-cycle pulse when a transfer is aborted
//
// Handshake: a master requests by holding any psel bit high and is stalled
// (pready=0) until its transfer completes; completion is the single cycle
// in which its pready=1 with prdata valid. Downstream, a transfer is one
// SETUP cycle (psel, penable=0) followed by ACCESS cycles (penable=1) that
// end on the first cycle with s_pready=1 or when the timeout fires.
//
// The FSM state register `state` (arb_state_t) and the one-hot `grant`
// together describe the arbiter's position in a transfer.
module apb_master_arbiter
  import apb_arb_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter int                NSEL       = ARB_NSEL_DEF,
  parameter int                FIXED_PRIO = 0,
  parameter int                TIMEOUT    = 255,
  parameter logic [DATA_W-1:0] ERR_DATA   = DATA_W'(ARB_ERR_DATA_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NSEL-1:0]   m0_psel,
  input  logic [NSEL-1:0]   m1_psel,
  input  logic              m0_penable,
  input  logic              m1_penable,
  input  logic              m0_pwrite,
  input  logic              m1_pwrite,
  input  logic [ADDR_W-1:0] m0_paddr,
  input  logic [ADDR_W-1:0] m1_paddr,
  input  logic [DATA_W-1:0] m0_pwdata,
  input  logic [DATA_W-1:0] m1_pwdata,
  output logic              m0_pready,
  output logic              m1_pready,
  output logic [DATA_W-1:0] m0_prdata,
  output logic [DATA_W-1:0] m1_prdata,
  output logic [NSEL-1:0]   s_psel,
  output logic              s_penable,
  output logic              s_pwrite,
  output logic [ADDR_W-1:0] s_paddr,
  output logic [DATA_W-1:0] s_pwdata,
  input  logic              s_pready,
  input  logic [DATA_W-1:0] s_prdata,
  output logic [1:0]        grant,
  output logic              timeout
);

  localparam int             CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  arb_state_t        state, state_nxt;
  logic [1:0]        win;
  logic              last_m1;      // 1 = master 1 owned the last completed transfer
  logic [CNT_W-1:0]  cnt;
  logic [NSEL-1:0]   lat_psel;
  logic              lat_pwrite;
  logic [ADDR_W-1:0] lat_paddr;
  logic [DATA_W-1:0] lat_pwdata;
  logic              done;         // downstream completed normally
  logic              abort;        // access phase ran out of cycles
  logic              finish;
  logic              busy;
  logic [DATA_W-1:0] resp_data;

  // The master-side access phase carries no extra information: a master is
  // stalled from its setup cycle until we complete it, so psel alone is the
  // request.
  logic unused_penable;
  assign unused_penable = m0_penable ^ m1_penable;

  apb_arb_pick2 #(
    .FIXED_PRIO (FIXED_PRIO)
  ) u_pick (
    .req  ({|m1_psel, |m0_psel}),
    .last (last_m1),
    .win  (win)
  );

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    abort     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (|win) state_nxt = ST_SETUP;
      end
      ST_SETUP: begin
        state_nxt = ST_ACCESS;
      end
      ST_ACCESS: begin
        // A late s_pready on the final allowed cycle still wins over abort.
        if (s_pready) begin
          done      = 1'b1;
          state_nxt = ST_IDLE;
        end else if ((TIMEOUT != 0) && (cnt == CNT_LAST)) begin
          abort     = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign finish = done | abort;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      grant      <= 2'b00;
      last_m1    <= 1'b1;
      cnt        <= '0;
      lat_psel   <= '0;
      lat_pwrite <= 1'b0;
      lat_paddr  <= '0;
      lat_pwdata <= '0;
    end else begin
      state <= state_nxt;

      if ((state == ST_IDLE) && (|win)) begin
        grant      <= win;
        lat_psel   <= win[1] ? m1_psel   : m0_psel;
        lat_pwrite <= win[1] ? m1_pwrite : m0_pwrite;
        lat_paddr  <= win[1] ? m1_paddr  : m0_paddr;
        lat_pwdata <= win[1] ? m1_pwdata : m0_pwdata;
      end

      if (finish) begin
        grant   <= 2'b00;
        last_m1 <= grant[1];
      end

      if ((state == ST_ACCESS) && !finish) cnt <= cnt + 1'b1;
      else                                 cnt <= '0;
    end
  end

  // Downstream port is driven only from the captured copy, and only while a
  // transfer is in flight, so master-side changes after capture are invisible.
  assign busy      = (state != ST_IDLE);
  assign s_psel    = busy ? lat_psel : '0;
  assign s_penable = (state == ST_ACCESS);
  assign s_pwrite  = busy & lat_pwrite;
  assign s_paddr   = busy ? lat_paddr  : '0;
  assign s_pwdata  = busy ? lat_pwdata : '0;

  assign resp_data = done ? s_prdata : ERR_DATA;
  assign m0_pready = finish & grant[0];
  assign m1_pready = finish & grant[1];
  assign m0_prdata = m0_pready ? resp_data : '0;
  assign m1_prdata = m1_pready ? resp_data : '0;
  assign timeout   = abort;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Bench for apb_master_arbiter. Two instances share all stimulus:
//   dut_a : round-robin, TIMEOUT=4
//   dut_b : fixed priority, TIMEOUT=255
// use_b selects which instance's outputs are observed by the checks.
module tb_apb_master_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  m0_psel, m1_psel;
  logic        m0_penable, m1_penable, m0_pwrite, m1_pwrite;
  logic [31:0] m0_paddr, m1_paddr, m0_pwdata, m1_pwdata;
  logic        s_pready;
  logic [31:0] s_prdata;

  logic        a_m0_pready, a_m1_pready, b_m0_pready, b_m1_pready;
  logic [31:0] a_m0_prdata, a_m1_prdata, b_m0_prdata, b_m1_prdata;
  logic [7:0]  a_s_psel, b_s_psel;
  logic        a_s_penable, b_s_penable, a_s_pwrite, b_s_pwrite;
  logic [31:0] a_s_paddr, b_s_paddr, a_s_pwdata, b_s_pwdata;
  logic [1:0]  a_grant, b_grant;
  logic        a_timeout, b_timeout;

  logic        use_b;
  logic        o_m0_pready, o_m1_pready, o_s_penable, o_s_pwrite, o_timeout;
  logic [31:0] o_m0_prdata, o_m1_prdata, o_s_paddr, o_s_pwdata;
  logic [7:0]  o_s_psel;
  logic [1:0]  o_grant;

  int checks   = 0;
  int failures = 0;
  logic [1:0] exp_q[$];

  always #5 clk = ~clk;

  apb_master_arbiter #(.FIXED_PRIO(0), .TIMEOUT(4)) dut_a (
    .clk(clk), .rst(rst),
    .m0_psel(m0_psel), .m1_psel(m1_psel),
    .m0_penable(m0_penable), .m1_penable(m1_penable),
    .m0_pwrite(m0_pwrite), .m1_pwrite(m1_pwrite),
    .m0_paddr(m0_paddr), .m1_paddr(m1_paddr),
    .m0_pwdata(m0_pwdata), .m1_pwdata(m1_pwdata),
    .m0_pready(a_m0_pready), .m1_pready(a_m1_pready),
    .m0_prdata(a_m0_prdata), .m1_prdata(a_m1_prdata),
    .s_psel(a_s_psel), .s_penable(a_s_penable), .s_pwrite(a_s_pwrite),
    .s_paddr(a_s_paddr), .s_pwdata(a_s_pwdata),
    .s_pready(s_pready), .s_prdata(s_prdata),
    .grant(a_grant), .timeout(a_timeout)
  );

  apb_master_arbiter #(.FIXED_PRIO(1), .TIMEOUT(255)) dut_b (
    .clk(clk), .rst(rst),
    .m0_psel(m0_psel), .m1_psel(m1_psel),
    .m0_penable(m0_penable), .m1_penable(m1_penable),
    .m0_pwrite(m0_pwrite), .m1_pwrite(m1_pwrite),
    .m0_paddr(m0_paddr), .m1_paddr(m1_paddr),
    .m0_pwdata(m0_pwdata), .m1_pwdata(m1_pwdata),
    .m0_pready(b_m0_pready), .m1_pready(b_m1_pready),
    .m0_prdata(b_m0_prdata), .m1_prdata(b_m1_prdata),
    .s_psel(b_s_psel), .s_penable(b_s_penable), .s_pwrite(b_s_pwrite),
    .s_paddr(b_s_paddr), .s_pwdata(b_s_pwdata),
    .s_pready(s_pready), .s_prdata(s_prdata),
    .grant(b_grant), .timeout(b_timeout)
  );

  assign o_m0_pready = use_b ? b_m0_pready : a_m0_pready;
  assign o_m1_pready = use_b ? b_m1_pready : a_m1_pready;
  assign o_m0_prdata = use_b ? b_m0_prdata : a_m0_prdata;
  assign o_m1_prdata = use_b ? b_m1_prdata : a_m1_prdata;
  assign o_s_psel    = use_b ? b_s_psel    : a_s_psel;
  assign o_s_penable = use_b ? b_s_penable : a_s_penable;
  assign o_s_pwrite  = use_b ? b_s_pwrite  : a_s_pwrite;
  assign o_s_paddr   = use_b ? b_s_paddr   : a_s_paddr;
  assign o_s_pwdata  = use_b ? b_s_pwdata  : a_s_pwdata;
  assign o_grant     = use_b ? b_grant     : a_grant;
  assign o_timeout   = use_b ? b_timeout   : a_timeout;

  typedef struct {
    logic        m;
    logic        wr;
    logic [31:0] addr;
    logic [7:0]  psel;
    logic [31:0] wdata;
    int          waits;
    logic [31:0] srdata;
    logic [1:0]  exp_grant;
    logic [31:0] exp_prdata;
  } vec_t;

  vec_t vecs[4];

  // ---------------- clock / reset ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m0_psel = '0; m1_psel = '0; m0_penable = 1'b0; m1_penable = 1'b0;
    m0_pwrite = 1'b0; m1_pwrite = 1'b0; m0_paddr = '0; m1_paddr = '0;
    m0_pwdata = '0; m1_pwdata = '0; s_pready = 1'b0; s_prdata = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // ---------------- scoreboard compare ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic set_m(input logic m, input logic [7:0] psel, input logic en,
                       input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
    if (!m) begin
      m0_psel = psel; m0_penable = en; m0_pwrite = wr; m0_paddr = addr; m0_pwdata = wdata;
    end else begin
      m1_psel = psel; m1_penable = en; m1_pwrite = wr; m1_paddr = addr; m1_pwdata = wdata;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_s_psel"},    o_s_psel, 0);
    check({tag, "_s_penable"}, o_s_penable, 0);
    check({tag, "_s_pwrite"},  o_s_pwrite, 0);
    check({tag, "_s_paddr"},   o_s_paddr, 0);
    check({tag, "_s_pwdata"},  o_s_pwdata, 0);
    check({tag, "_grant"},     o_grant, 0);
    check({tag, "_timeout"},   o_timeout, 0);
    check({tag, "_pready"},    {o_m1_pready, o_m0_pready}, 0);
    check({tag, "_prdata"},    {o_m1_prdata, o_m0_prdata}, 0);
  endtask

  // One uncontended transfer; master inputs are scrambled after capture to
  // confirm the downstream side keeps the captured values.
  task automatic xfer(input vec_t v);
    logic        rdy, other_rdy;
    logic [31:0] rd, other_rd;
    set_m(v.m, v.psel, 1'b0, v.wr, v.addr, v.wdata);
    s_pready = 1'b0; s_prdata = '0;
    #1;
    check("req_s_psel", o_s_psel, 0);
    check("req_grant",  o_grant, 0);
    tick();
    set_m(v.m, v.psel, 1'b1, v.wr, v.addr, v.wdata);
    #1;
    check("setup_s_psel",    o_s_psel, v.psel);
    check("setup_s_penable", o_s_penable, 0);
    check("setup_grant",     o_grant, v.exp_grant);
    check("setup_s_paddr",   o_s_paddr, v.addr);
    check("setup_s_pwrite",  o_s_pwrite, v.wr);
    check("setup_s_pwdata",  o_s_pwdata, v.wdata);
    tick();
    for (int k = 0; k <= v.waits; k++) begin
      s_pready = (k == v.waits);
      s_prdata = (k == v.waits) ? v.srdata : 32'h0BAD_0BAD;
      set_m(v.m, v.psel, 1'b1, ~v.wr, ~v.addr, ~v.wdata);
      #1;
      rdy       = v.m ? o_m1_pready : o_m0_pready;
      other_rdy = v.m ? o_m0_pready : o_m1_pready;
      rd        = v.m ? o_m1_prdata : o_m0_prdata;
      other_rd  = v.m ? o_m0_prdata : o_m1_prdata;
      check("acc_s_penable", o_s_penable, 1);
      check("acc_s_psel",    o_s_psel, v.psel);
      check("acc_s_paddr",   o_s_paddr, v.addr);
      check("acc_s_pwrite",  o_s_pwrite, v.wr);
      check("acc_s_pwdata",  o_s_pwdata, v.wdata);
      check("acc_pready",    rdy, (k == v.waits));
      check("acc_prdata",    rd, (k == v.waits) ? v.exp_prdata : 32'h0);
      check("acc_other",     {other_rdy, other_rd}, 0);
      check("acc_timeout",   o_timeout, 0);
      tick();
    end
    set_m(v.m, 8'h00, 1'b0, 1'b0, 32'h0, 32'h0);
    s_pready = 1'b0;
    #1;
    check("end_s_psel",    o_s_psel, 0);
    check("end_s_penable", o_s_penable, 0);
    check("end_grant",     o_grant, 0);
    tick();
  endtask

  // Both masters keep requesting until each has completed four transfers;
  // the completion order is checked against exp_q.
  task automatic contend(input string tag);
    int         done0, done1, cyc;
    logic [1:0] got;
    done0 = 0; done1 = 0; cyc = 0;
    s_pready = 1'b1;
    s_prdata = 32'h1111_2222;
    while ((done0 < 4 || done1 < 4) && cyc < 200) begin
      set_m(1'b0, (done0 < 4) ? 8'h01 : 8'h00, 1'b0, 1'b0, 32'h100 + done0, 32'h0);
      set_m(1'b1, (done1 < 4) ? 8'h02 : 8'h00, 1'b0, 1'b1, 32'h200 + done1, 32'h5);
      #1;
      got = {o_m1_pready, o_m0_pready};
      if (got != 2'b00) begin
        if (exp_q.size() == 0) check({tag, "_extra"}, got, 0);
        else                   check({tag, "_order"}, got, exp_q.pop_front());
        check({tag, "_grant"}, o_grant, got);
        if (got[0]) done0++;
        if (got[1]) done1++;
      end
      tick();
      cyc++;
    end
    check({tag, "_left"}, exp_q.size(), 0);
    s_pready = 1'b0;
    set_m(1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 32'h0);
    set_m(1'b1, 8'h00, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
  endtask

  initial begin
    vec_t wv, fresh;

    vecs[0] = '{m: 1'b0, wr: 1'b0, addr: 32'h0000_0010, psel: 8'h01, wdata: 32'h0,
                waits: 0, srdata: 32'h1234_5678, exp_grant: 2'b01, exp_prdata: 32'h1234_5678};
    vecs[1] = '{m: 1'b1, wr: 1'b1, addr: 32'h0000_0020, psel: 8'h02, wdata: 32'hCAFE_F00D,
                waits: 1, srdata: 32'h0, exp_grant: 2'b10, exp_prdata: 32'h0};
    vecs[2] = '{m: 1'b0, wr: 1'b1, addr: 32'hFFFF_FFFC, psel: 8'h80, wdata: 32'hFFFF_FFFF,
                waits: 2, srdata: 32'h0000_0001, exp_grant: 2'b01, exp_prdata: 32'h0000_0001};
    // s_pready on the 4th access cycle with TIMEOUT=4: completes, no abort.
    vecs[3] = '{m: 1'b1, wr: 1'b0, addr: 32'h0000_0000, psel: 8'h04, wdata: 32'h0,
                waits: 3, srdata: 32'hA5A5_5A5A, exp_grant: 2'b10, exp_prdata: 32'hA5A5_5A5A};

    // ---- reset state, both instances ----
    use_b = 1'b0;
    do_reset();
    #1;
    check_all_zero("rst_a");
    use_b = 1'b1;
    #1;
    check_all_zero("rst_b");
    tick();

    // ---- table-driven single transfers on dut_a ----
    use_b = 1'b0;
    for (int i = 0; i < 4; i++) xfer(vecs[i]);

    // ---- round-robin contention from reset ----
    do_reset();
    use_b = 1'b0;
    exp_q = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
    contend("rr");

    // ---- fixed-priority contention from reset ----
    do_reset();
    use_b = 1'b1;
    exp_q = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10};
    contend("fp");

    // ---- five wait states, m1 write, dut_b ----
    do_reset();
    use_b = 1'b1;
    wv = '{m: 1'b1, wr: 1'b1, addr: 32'h0000_0300, psel: 8'h10, wdata: 32'hCAFE_F00D,
           waits: 5, srdata: 32'h0000_00EE, exp_grant: 2'b10, exp_prdata: 32'h0000_00EE};
    xfer(wv);

    // ---- timeout on dut_a (TIMEOUT=4) ----
    do_reset();
    use_b = 1'b0;
    set_m(1'b0, 8'h08, 1'b0, 1'b0, 32'h40, 32'h0);
    tick();
    set_m(1'b0, 8'h08, 1'b1, 1'b0, 32'h40, 32'h0);
    tick();
    for (int k = 1; k <= 4; k++) begin
      #1;
      check("to_s_penable", o_s_penable, 1);
      check("to_timeout",   o_timeout, (k == 4));
      check("to_m0_pready", o_m0_pready, (k == 4));
      check("to_m0_prdata", o_m0_prdata, (k == 4) ? 32'hDEAD_BEEF : 32'h0);
      check("to_m1_pready", o_m1_pready, 0);
      tick();
    end
    set_m(1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    check("to_after_s_psel",    o_s_psel, 0);
    check("to_after_s_penable", o_s_penable, 0);
    check("to_after_timeout",   o_timeout, 0);
    check("to_after_grant",     o_grant, 0);
    tick();

    // ---- reset in the middle of an access phase ----
    do_reset();
    use_b = 1'b0;
    set_m(1'b1, 8'h02, 1'b0, 1'b0, 32'h77, 32'h0);
    tick();
    set_m(1'b1, 8'h02, 1'b1, 1'b0, 32'h77, 32'h0);
    tick();
    #1;
    check("mid_s_penable", o_s_penable, 1);
    check("mid_grant",     o_grant, 2'b10);
    rst = 1'b1;
    tick();
    s_pready = 1'b1;
    s_prdata = 32'h9999_9999;
    #1;
    check_all_zero("mid_rst");
    rst = 1'b0;
    s_pready = 1'b0;
    set_m(1'b1, 8'h00, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    fresh = '{m: 1'b0, wr: 1'b0, addr: 32'h0000_0010, psel: 8'h01, wdata: 32'h0,
              waits: 0, srdata: 32'h0F0F_0F0F, exp_grant: 2'b01, exp_prdata: 32'h0F0F_0F0F};
    xfer(fresh);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
